rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single combinational, byte-addressed instruction ROM between two requesters: the fetch stage (IF) and a data-side read port (LD) for constant-pool loads.
- Arbitrates one access per cycle and presents a word-aligned address to the ROM.
- Registers the returned word, and for LD performs RISC-V size/sign extraction (LB/LH/LW/LBU/LHU).
- Sits between the fetch/memory stages and the ROM; the ROM itself is unchanged.

Parameters:
ADDRESS_WIDTH, 32, width of all addresses
DATA_WIDTH, 32, ROM word / response width
ROM_BASE, 32'hBFC00000, first byte address of the ROM window
ROM_SIZE, 32'h00001000, ROM window size in bytes
MAX_LD_STREAK, 3, consecutive LD grants allowed while IF is waiting

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDRESS_WIDTH  fetch byte address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch response valid (registered)
if_rdata  out  DATA_WIDTH  fetched instruction
if_err  out  1  fetch fault (misaligned or out of window)
ld_req  in  1  data read request, held until ld_gnt
ld_addr  in  ADDRESS_WIDTH  data byte address
ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
ld_gnt  out  1  data request accepted this cycle (combinational)
ld_rvalid  out  1  data response valid (registered)
ld_rdata  out  DATA_WIDTH  extracted, extended load data
ld_err  out  1  data fault (misaligned, out of window, illegal funct3)
rom_a  out  ADDRESS_WIDTH  address to ROM, always word-aligned
rom_rd  in  DATA_WIDTH  ROM word, little-endian, combinational from rom_a

Behaviour:
- Reset (sync, rst=1 at clk edge): if_rvalid, ld_rvalid, if_err, ld_err = 0; if_rdata, ld_rdata = 0; streak counter = 0.
- if_gnt and ld_gnt are forced 0 while rst=1.
- Arbitration (combinational, at most one grant per cycle):
  - LD wins over IF unless streak == MAX_LD_STREAK and if_req=1; in that case IF wins.
  - Only one requesting → that one is granted.
  - Neither requesting → no grant; rom_a = {if_addr[31:2],2'b00}.
- Streak counter: +1 on each LD grant while if_req=1; cleared on any IF grant or any cycle with if_req=0. Saturates at MAX_LD_STREAK.
- rom_a = {granted_addr[ADDRESS_WIDTH-1:2], 2'b00}.
- Latency: response registered on the clk edge ending the grant cycle.
  - Granted side's rvalid = 1 for exactly one cycle.
  - Non-granted side's rvalid = 0.
  - rdata/err hold their last value when rvalid=0.
- Faults:
  - Window check: aligned word address must satisfy ROM_BASE <= addr <= ROM_BASE+ROM_SIZE-4.
  - IF: error if addr[1:0] != 0 or out of window.
  - LD: error if LH/LHU with addr[0]=1, LW with addr[1:0]!=0, funct3 not in {000,001,010,100,101}, or out of window.
  - On error: rvalid=1, err=1, rdata=0; the grant still occurs (the request is consumed).
- LD extraction:
  - Byte = rom_rd[8*addr[1:0] +: 8].
  - Half = rom_rd[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
- Back-to-back: a requester may hold req high continuously.
  - A new grant is allowed every cycle.
  - No duplicate accept: the requester must change address/req after gnt.
- Address arithmetic is unsigned, ADDRESS_WIDTH wide. ROM_BASE+ROM_SIZE-4 is computed without overflow; parameters guarantee it fits.
- Reset mid-operation: a response scheduled for the next edge is dropped. Requests present during reset are not granted and must be re-presented.

Test Plan:
- Reset with if_req=ld_req=1 → gnts 0 during reset; all rvalid/err/rdata 0 on first cycle after reset.
- IF only, if_addr=BFC00004, rom_rd=00500093 → if_gnt same cycle, rom_a=BFC00004; next cycle if_rvalid=1, if_rdata=00500093, if_err=0.
- LD LB at BFC00013, rom_rd=80FF1234 → rom_a=BFC00010; ld_rdata=FFFFFF80. Same address with LBU → 00000080. LH at BFC00012 → FFFF80FF.
- Both requesting continuously, MAX_LD_STREAK=3 → grant sequence LD,LD,LD,IF,LD,LD,LD,IF; no cycle with both gnts.
- Faults: IF at BFC00002 → if_err=1, if_rdata=0. LW at BFC00FFD → ld_err=1. LD funct3=011 → ld_err=1. LW at BFC01000 → ld_err=1. LW at BFC00FFC → valid, no error.
- rst asserted in cycle after an IF grant → if_rvalid stays 0; request re-presented after reset completes normally.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational, byte-addressed instruction ROM
// between the fetch stage (IF) and a data-side constant-pool read port (LD).
// Each cycle it grants at most one access, drives a word-aligned ROM address,
// and registers the response. LD responses get RISC-V size/sign extraction.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_gnt) and byte address
//   if_gnt                   fetch accepted this cycle (combinational)
//   if_rvalid/rdata/err      registered fetch response
//   ld_req/ld_addr/ld_funct3 data read request, byte address, load type
//   ld_gnt                   data request accepted this cycle (combinational)
//   ld_rvalid/rdata/err      registered, extracted and extended load response
//   rom_a / rom_rd           word-aligned ROM address / little-endian ROM word
module rom_port_arbiter #(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter int unsigned               DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  ROM_BASE      = 32'hBFC00000,
    parameter logic [ADDRESS_WIDTH-1:0]  ROM_SIZE      = 32'h00001000,
    parameter int unsigned               MAX_LD_STREAK = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    output logic                     if_err,
    input  logic                     ld_req,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic [2:0]               ld_funct3,
    output logic                     ld_gnt,
    output logic                     ld_rvalid,
    output logic [DATA_WIDTH-1:0]    ld_rdata,
    output logic                     ld_err,
    output logic [ADDRESS_WIDTH-1:0] rom_a,
    input  logic [DATA_WIDTH-1:0]    rom_rd
);

    localparam int unsigned STREAK_W = (MAX_LD_STREAK < 1) ? 1 : $clog2(MAX_LD_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LD_STREAK);
    // Last legal word address; parameters guarantee no overflow.
    localparam logic [ADDRESS_WIDTH-1:0] ROM_LAST = ROM_BASE + ROM_SIZE - ADDRESS_WIDTH'(4);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [STREAK_W-1:0]      r_streak;
    logic                     r_if_rvalid;
    logic [DATA_WIDTH-1:0]    r_if_rdata;
    logic                     r_if_err;
    logic                     r_ld_rvalid;
    logic [DATA_WIDTH-1:0]    r_ld_rdata;
    logic                     r_ld_err;

    logic                     w_if_starved;
    logic                     w_sel_ld;
    logic                     w_if_gnt;
    logic                     w_ld_gnt;
    logic [ADDRESS_WIDTH-1:0] w_if_word;
    logic [ADDRESS_WIDTH-1:0] w_ld_word;
    logic                     w_if_fault;
    logic                     w_ld_fault;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [DATA_WIDTH-1:0]    w_ld_data;

    // Arbitration: LD has priority until IF has waited through MAX_LD_STREAK LD grants.
    always_comb begin
        w_if_starved = if_req && (r_streak == STREAK_MAX);
        w_sel_ld     = ld_req && !w_if_starved;
        w_ld_gnt     = !rst && w_sel_ld;
        w_if_gnt     = !rst && if_req && !w_sel_ld;
    end

    assign w_if_word = {if_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign w_ld_word = {ld_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign rom_a     = w_sel_ld ? w_ld_word : w_if_word;
    assign if_gnt    = w_if_gnt;
    assign ld_gnt    = w_ld_gnt;

    // Fault detection for both requesters.
    always_comb begin
        w_if_fault = (if_addr[1:0] != 2'b00) || (w_if_word < ROM_BASE) || (w_if_word > ROM_LAST);
        w_ld_fault = (w_ld_word < ROM_BASE) || (w_ld_word > ROM_LAST);
        case (ld_funct3)
            F3_LB, F3_LBU: ;
            F3_LH, F3_LHU: if (ld_addr[0]) w_ld_fault = 1'b1;
            F3_LW:         if (ld_addr[1:0] != 2'b00) w_ld_fault = 1'b1;
            default:       w_ld_fault = 1'b1;
        endcase
    end

    // LD lane extraction and extension.
    always_comb begin
        w_byte    = rom_rd[7:0];
        w_half    = ld_addr[1] ? rom_rd[31:16] : rom_rd[15:0];
        w_ld_data = rom_rd;
        case (ld_addr[1:0])
            2'd0: w_byte = rom_rd[7:0];
            2'd1: w_byte = rom_rd[15:8];
            2'd2: w_byte = rom_rd[23:16];
            2'd3: w_byte = rom_rd[31:24];
            default: w_byte = rom_rd[7:0];
        endcase
        case (ld_funct3)
            F3_LB:   w_ld_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_LBU:  w_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_LH:   w_ld_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_LHU:  w_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_ld_data = rom_rd;
        endcase
    end

    // Response registers and LD streak counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak    <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_ld_rvalid <= 1'b0;
            r_ld_rdata  <= '0;
            r_ld_err    <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_ld_rvalid <= w_ld_gnt;
            if (w_if_gnt) begin
                r_if_err   <= w_if_fault;
                r_if_rdata <= w_if_fault ? '0 : rom_rd;
            end
            if (w_ld_gnt) begin
                r_ld_err   <= w_ld_fault;
                r_ld_rdata <= w_ld_fault ? '0 : w_ld_data;
            end
            if (!if_req || w_if_gnt) begin
                r_streak <= '0;
            end else if (w_ld_gnt && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign ld_rvalid = r_ld_rvalid;
    assign ld_rdata  = r_ld_rdata;
    assign ld_err    = r_ld_err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios followed by a
// randomized phase checked against a behavioural model of the arbiter.
module tb_rom_port_arbiter;

    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam logic [31:0] SIZE = 32'h00001000;
    localparam int          MAXS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ld_req;
    logic [31:0] if_addr, ld_addr;
    logic [2:0]  ld_funct3;
    logic        if_gnt, if_rvalid, if_err;
    logic        ld_gnt, ld_rvalid, ld_err;
    logic [31:0] if_rdata, ld_rdata, rom_a, rom_rd;
    logic        rom_ovr_en;
    logic [31:0] rom_ovr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) * 32'h9E37_79B1 + 32'h8000_0081;
    endfunction

    assign rom_rd = rom_ovr_en ? rom_ovr : rom_word(rom_a);

    rom_port_arbiter #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ROM_BASE(BASE),
        .ROM_SIZE(SIZE), .MAX_LD_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .rom_a(rom_a), .rom_rd(rom_rd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_window(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return (w >= BASE) && (w <= BASE + SIZE - 32'd4);
    endfunction

    // Expected {err, data} for an IF access.
    function automatic logic [32:0] if_model(input logic [31:0] a, input logic [31:0] w);
        logic e;
        e = (a % 4 != 0) || !in_window(a);
        return {e, e ? 32'd0 : w};
    endfunction

    // Expected {err, data} for an LD access, computed with shifts and masks.
    function automatic logic [32:0] ld_model(input logic [31:0] a, input logic [2:0] f3,
                                             input logic [31:0] w);
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        logic        e;
        off = int'(a % 4);
        b   = 8'(w >> (8 * off));
        h   = 16'(w >> (16 * (off / 2)));
        e   = !in_window(a);
        d   = 32'd0;
        case (f3)
            3'd0: d = 32'($signed(b));
            3'd1: begin d = 32'($signed(h)); if (off % 2 != 0) e = 1'b1; end
            3'd2: begin d = w;               if (off != 0)     e = 1'b1; end
            3'd4: d = 32'(b);
            3'd5: begin d = 32'(h);          if (off % 2 != 0) e = 1'b1; end
            default: e = 1'b1;
        endcase
        return {e, e ? 32'd0 : d};
    endfunction

    task automatic if_once(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_e);
        if_req  = 1'b1;
        if_addr = a;
        #1;
        check({tag, "_gnt"}, 32'(if_gnt), 32'd1);
        check({tag, "_rom_a"}, rom_a, a & 32'hFFFF_FFFC);
        step();
        if_req = 1'b0;
        check({tag, "_rvalid"}, 32'(if_rvalid), 32'd1);
        check({tag, "_rdata"}, if_rdata, exp_d);
        check({tag, "_err"}, 32'(if_err), 32'(exp_e));
    endtask

    task automatic ld_once(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] exp_d, input logic exp_e);
        ld_req    = 1'b1;
        ld_addr   = a;
        ld_funct3 = f3;
        #1;
        check({tag, "_gnt"}, 32'(ld_gnt), 32'd1);
        check({tag, "_rom_a"}, rom_a, a & 32'hFFFF_FFFC);
        step();
        ld_req = 1'b0;
        check({tag, "_rvalid"}, 32'(ld_rvalid), 32'd1);
        check({tag, "_rdata"}, ld_rdata, exp_d);
        check({tag, "_err"}, 32'(ld_err), 32'(exp_e));
    endtask

    initial begin : stim
        logic        if_pend, ld_pend, e_if, e_ld, if_seen, ld_seen;
        logic [31:0] ia, la;
        logic [2:0]  lf;
        logic [32:0] exp_if, exp_ld;
        logic [7:0]  pattern;
        int          streak;

        rst = 1'b1; if_req = 1'b1; ld_req = 1'b1;
        if_addr = BASE; ld_addr = BASE; ld_funct3 = 3'd2;
        rom_ovr_en = 1'b1; rom_ovr = 32'd0;

        // Reset with both requests pending: no grants, clean outputs.
        step();
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        step();
        rst = 1'b0; if_req = 1'b0; ld_req = 1'b0;
        #1;
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("rst_if_err", 32'(if_err), 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ld_rdata", ld_rdata, 32'd0);
        step();

        // Single-requester accesses and LD extraction.
        rom_ovr = 32'h0050_0093;
        if_once("if_basic", 32'hBFC0_0004, 32'h0050_0093, 1'b0);
        step();
        check("if_rvalid_one_cycle", 32'(if_rvalid), 32'd0);
        check("if_rdata_hold", if_rdata, 32'h0050_0093);
        rom_ovr = 32'h80FF_1234;
        ld_once("ld_lb", 32'hBFC0_0013, 3'd0, 32'hFFFF_FF80, 1'b0);
        ld_once("ld_lbu", 32'hBFC0_0013, 3'd4, 32'h0000_0080, 1'b0);
        ld_once("ld_lh", 32'hBFC0_0012, 3'd1, 32'hFFFF_80FF, 1'b0);
        ld_once("ld_lhu_lo", 32'hBFC0_0010, 3'd5, 32'h0000_1234, 1'b0);
        ld_once("ld_lw", 32'hBFC0_0010, 3'd2, 32'h80FF_1234, 1'b0);
        step();

        // Fairness: both requesting continuously.
        pattern = 8'b1110_1110;
        if_req = 1'b1; ld_req = 1'b1; if_addr = BASE; ld_addr = BASE; ld_funct3 = 3'd2;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("streak_ld_gnt%0d", i), 32'(ld_gnt), 32'(pattern[7-i]));
            check($sformatf("streak_if_gnt%0d", i), 32'(if_gnt), 32'(!pattern[7-i]));
            step();
        end
        if_req = 1'b0; ld_req = 1'b0;
        step();

        // Faults and window boundaries.
        if_once("if_misalign", 32'hBFC0_0002, 32'd0, 1'b1);
        ld_once("lw_misalign", 32'hBFC0_0FFD, 3'd2, 32'd0, 1'b1);
        ld_once("ld_f3_011", 32'hBFC0_0100, 3'd3, 32'd0, 1'b1);
        ld_once("lw_past_end", 32'hBFC0_1000, 3'd2, 32'd0, 1'b1);
        ld_once("lw_below_base", 32'hBFBF_FFFC, 3'd2, 32'd0, 1'b1);
        ld_once("lw_last_word", 32'hBFC0_0FFC, 3'd2, 32'h80FF_1234, 1'b0);
        step();
        check("ld_err_hold", 32'(ld_err), 32'd0);

        // Reset after a grant drops the response; re-presented request completes.
        rom_ovr = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'hBFC0_0008;
        #1;
        check("midrst_gnt", 32'(if_gnt), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_gnt_forced", 32'(if_gnt), 32'd0);
        step();
        check("midrst_rvalid", 32'(if_rvalid), 32'd0);
        step();
        rst = 1'b0;
        if_once("midrst_retry", 32'hBFC0_0008, 32'hDEAD_BEEF, 1'b0);
        step();

        // Randomized traffic against the behavioural model.
        rom_ovr_en = 1'b0;
        if_pend = 1'b0; ld_pend = 1'b0; if_seen = 1'b0; ld_seen = 1'b0;
        ia = BASE; la = BASE; lf = 3'd0; streak = 0;
        exp_if = '0; exp_ld = '0;
        for (int c = 0; c < 400; c++) begin
            if (!if_pend && $urandom_range(0, 3) != 0) begin
                if_pend = 1'b1;
                ia = BASE - 32'd8 + 32'($urandom_range(0, 32'h1010));
                if ($urandom_range(0, 1) == 1) ia = ia & 32'hFFFF_FFFC;
            end
            if (!ld_pend && $urandom_range(0, 3) != 0) begin
                ld_pend = 1'b1;
                la = BASE - 32'd8 + 32'($urandom_range(0, 32'h1010));
                lf = 3'($urandom_range(0, 7));
            end
            if_req = if_pend; if_addr = ia;
            ld_req = ld_pend; ld_addr = la; ld_funct3 = lf;
            #1;
            // IF is owed the port once it has watched MAXS LD grants in a row.
            e_ld = ld_pend && !(if_pend && streak == MAXS);
            e_if = if_pend && !e_ld;
            check("rnd_ld_gnt", 32'(ld_gnt), 32'(e_ld));
            check("rnd_if_gnt", 32'(if_gnt), 32'(e_if));
            if (e_ld || e_if)
                check("rnd_rom_a", rom_a, (e_ld ? la : ia) & 32'hFFFF_FFFC);
            if (e_if) begin
                exp_if = if_model(ia, rom_word(ia & 32'hFFFF_FFFC));
                if_seen = 1'b1;
            end
            if (e_ld) begin
                exp_ld = ld_model(la, lf, rom_word(la & 32'hFFFF_FFFC));
                ld_seen = 1'b1;
            end
            if (!if_pend || e_if) streak = 0;
            else if (e_ld && streak < MAXS) streak++;
            step();
            check("rnd_if_rvalid", 32'(if_rvalid), 32'(e_if));
            check("rnd_ld_rvalid", 32'(ld_rvalid), 32'(e_ld));
            if (if_seen) begin
                check("rnd_if_rdata", if_rdata, exp_if[31:0]);
                check("rnd_if_err", 32'(if_err), 32'(exp_if[32]));
            end
            if (ld_seen) begin
                check("rnd_ld_rdata", ld_rdata, exp_ld[31:0]);
                check("rnd_ld_err", 32'(ld_err), 32'(exp_ld[32]));
            end
            if (e_if) if_pend = 1'b0;
            if (e_ld) ld_pend = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
